// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack port between the memory stage and data memory
interface mem_stage_if #(
   parameter int ADDR_W = 10
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [18:0]       wdata;
   logic [18:0]       rdata;
   logic              ack;
   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: load/store stage with req/ack memory port, execute stall and timeout watchdog
module mem_stage #(
   parameter int         ADDR_W  = 10,
   parameter logic [4:0] OP_NOP  = 5'b00000,
   parameter logic [4:0] OP_LD   = 5'b01100,
   parameter logic [4:0] OP_ST   = 5'b01101,
   parameter int         TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [4:0]  opcode_in,
   input  logic [18:0] alu_result_in,
   input  logic [18:0] store_data_in,
   input  logic [2:0]  rd_in,
   output logic        stall_out,
   mem_stage_if.master mem,
   output logic        valid_out,
   output logic [18:0] result_out,
   output logic [2:0]  rd_out,
   output logic        reg_write_out,
   output logic        err_out
);
   typedef enum logic {IDLE, WAIT} state_t;
   localparam int CW = $clog2(TIMEOUT);
   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              is_ld, is_ld_n;
   logic [2:0]        rd_q, rd_q_n;
   logic              req_n, we_n, stall_n, valid_n, rw_n, err_n;
   logic [ADDR_W-1:0] addr_n;
   logic [18:0]       wdata_n, result_n;
   logic [2:0]        rd_n;
   logic              mem_op, done;
   assign mem_op = opcode_in == OP_LD || opcode_in == OP_ST;
   assign done   = mem.ack || cnt == CW'(TIMEOUT - 1);
   // state and all registered outputs; reset discards any outstanding access
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         is_ld         <= 1'b0;
         rd_q          <= '0;
         mem.req       <= 1'b0;
         mem.we        <= 1'b0;
         mem.addr      <= '0;
         mem.wdata     <= '0;
         stall_out     <= 1'b0;
         valid_out     <= 1'b0;
         reg_write_out <= 1'b0;
         result_out    <= '0;
         rd_out        <= '0;
         err_out       <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         is_ld         <= is_ld_n;
         rd_q          <= rd_q_n;
         mem.req       <= req_n;
         mem.we        <= we_n;
         mem.addr      <= addr_n;
         mem.wdata     <= wdata_n;
         stall_out     <= stall_n;
         valid_out     <= valid_n;
         reg_write_out <= rw_n;
         result_out    <= result_n;
         rd_out        <= rd_n;
         err_out       <= err_n;
      end
   end
   // IDLE retires ALU ops or launches an access; WAIT ends on ack (wins) or watchdog abort
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      is_ld_n  = is_ld;
      rd_q_n   = rd_q;
      req_n    = mem.req;
      we_n     = mem.we;
      addr_n   = mem.addr;
      wdata_n  = mem.wdata;
      stall_n  = stall_out;
      valid_n  = 1'b0;
      rw_n     = 1'b0;
      result_n = result_out;
      rd_n     = rd_out;
      err_n    = err_out;
      if (state == IDLE) begin
         if (valid_in && mem_op) begin
            state_n = WAIT;
            cnt_n   = '0;
            is_ld_n = opcode_in == OP_LD;
            rd_q_n  = rd_in;
            req_n   = 1'b1;
            we_n    = opcode_in == OP_ST;
            addr_n  = alu_result_in[ADDR_W-1:0];
            wdata_n = store_data_in;
            stall_n = 1'b1;
         end else if (valid_in) begin
            valid_n  = 1'b1;
            result_n = alu_result_in;
            rd_n     = rd_in;
            rw_n     = opcode_in != OP_NOP;
         end
      end else if (done) begin
         state_n  = IDLE;
         req_n    = 1'b0;
         stall_n  = 1'b0;
         valid_n  = 1'b1;
         rd_n     = rd_q;
         rw_n     = mem.ack && is_ld;
         result_n = mem.ack && is_ld ? mem.rdata : result_out;
         err_n    = err_out | ~mem.ack;
      end else begin
         cnt_n = cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test of mem_stage against a retirement scoreboard
module tb_mem_stage;
   localparam logic [4:0] NOP = 5'b00000, ADD = 5'b00001, LD = 5'b01100, ST = 5'b01101;
   logic        clk = 0, reset = 0, valid_in = 0;
   logic [4:0]  opcode_in = '0;
   logic [18:0] alu_result_in = '0, store_data_in = '0;
   logic [2:0]  rd_in = '0;
   logic        stall_out, valid_out, reg_write_out, err_out;
   logic [18:0] result_out;
   logic [2:0]  rd_out;
   mem_stage_if #(.ADDR_W(10)) mem ();
   mem_stage dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .opcode_in(opcode_in),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in), .rd_in(rd_in),
      .stall_out(stall_out), .mem(mem), .valid_out(valid_out), .result_out(result_out),
      .rd_out(rd_out), .reg_write_out(reg_write_out), .err_out(err_out)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [18:0] result;
      logic [2:0]  rd;
      logic        rw;
      logic        keep;
      logic        abort;
   } exp_t;
   exp_t        q[$];
   exp_t        e;
   int          n_checks = 0, n_err = 0;
   logic [18:0] last_result = '0;
   logic        err_model = 0, chk_en = 0;
   logic [9:0]  exp_addr = '0, cap_addr = '0;
   logic        exp_we = 0, cap_we = 0;
   logic [18:0] exp_wdata = '0, cap_wdata = '0;
   int          ack_at = 0;
   logic [18:0] rdata_cfg = '0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // memory model: acks in the ack_at-th WAIT cycle (0 = never)
   initial begin
      int w;
      w = 0;
      mem.ack = 0;
      mem.rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem.req) begin
            w++;
            mem.ack = ack_at != 0 && w == ack_at;
            mem.rdata = rdata_cfg;
         end else begin
            w = 0;
            mem.ack = 0;
         end
      end
   end
   // per-cycle compare against the scoreboard
   always @(negedge clk) begin
      if (chk_en && reset) begin
         if (mem.req) begin
            chk("mem_addr", 32'(mem.addr), 32'(exp_addr));
            chk("mem_we", 32'(mem.we), 32'(exp_we));
            chk("mem_wdata", 32'(mem.wdata), 32'(exp_wdata));
            cap_addr = mem.addr;
            cap_we = mem.we;
            cap_wdata = mem.wdata;
         end
         chk("rw_gated", 32'(reg_write_out & ~valid_out), 0);
         if (valid_out) begin
            chk("retire_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               if (!e.abort) begin
                  chk("result_out", 32'(result_out), 32'(e.keep ? last_result : e.result));
                  chk("rd_out", 32'(rd_out), 32'(e.rd));
                  if (!e.keep) last_result = e.result;
               end
               chk("reg_write_out", 32'(reg_write_out), 32'(e.rw));
               if (e.abort) err_model = 1;
            end
         end
         chk("err_out", 32'(err_out), 32'(err_model));
      end
   end
   task automatic issue(input logic [4:0] op, input logic [18:0] alu, input logic [18:0] sd,
                        input logic [2:0] rd, input int ack, input logic [18:0] rdat);
      logic memop, acked;
      int   st, exp_stall;
      exp_t x;
      memop = op == LD || op == ST;
      acked = ack >= 1 && ack <= 16;
      st = 0;
      ack_at = ack;
      rdata_cfg = rdat;
      exp_addr = alu[9:0];
      exp_we = op == ST;
      exp_wdata = sd;
      x.rd = rd;
      x.keep = 0;
      x.abort = 0;
      x.result = alu;
      x.rw = op != NOP;
      if (memop) begin
         x.abort = !acked;
         x.keep = op == ST;
         x.result = rdat;
         x.rw = op == LD && acked;
      end
      q.push_back(x);
      opcode_in = op;
      alu_result_in = alu;
      store_data_in = sd;
      rd_in = rd;
      valid_in = 1;
      @(posedge clk);
      #1;
      while (stall_out && st < 100) begin
         st++;
         @(posedge clk);
         #1;
      end
      valid_in = 0;
      exp_stall = !memop ? 0 : acked ? ack : 16;
      chk("stall_cycles", st, exp_stall);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_req", 32'(mem.req), 0);
      chk("rst_stall", 32'(stall_out), 0);
      chk("rst_err", 32'(err_out), 0);
      chk("rst_result", 32'(result_out), 0);
      chk("rst_rd", 32'(rd_out), 0);
      reset = 1;
      chk_en = 1;
      @(posedge clk);
      #1;
      // 1: single-cycle ALU op
      issue(ADD, 19'h1ABCD, 19'h0, 3'd5, 0, 19'h0);
      chk("t1_valid", 32'(valid_out), 1);
      chk("t1_result", 32'(result_out), 32'h1ABCD);
      chk("t1_rd", 32'(rd_out), 5);
      chk("t1_rw", 32'(reg_write_out), 1);
      issue(NOP, 19'h00123, 19'h0, 3'd1, 0, 19'h0);
      chk("nop_rw", 32'(reg_write_out), 0);
      chk("nop_result", 32'(result_out), 32'h00123);
      // 2: store, upper address bits dropped; rdata must not be sampled
      issue(ST, 19'h7F123, 19'h00042, 3'd4, 4, 19'h3FFFF);
      chk("t2_addr", 32'(cap_addr), 32'h123);
      chk("t2_we", 32'(cap_we), 1);
      chk("t2_wdata", 32'(cap_wdata), 32'h42);
      chk("t2_valid", 32'(valid_out), 1);
      chk("t2_rw", 32'(reg_write_out), 0);
      chk("t2_result_kept", 32'(result_out), 32'h00123);
      // 3: load with one-cycle ack, then a queued op
      issue(LD, 19'h00010, 19'h0, 3'd3, 1, 19'h55555);
      chk("t3_result", 32'(result_out), 32'h55555);
      chk("t3_rd", 32'(rd_out), 3);
      chk("t3_rw", 32'(reg_write_out), 1);
      issue(ADD, 19'h00777, 19'h0, 3'd6, 0, 19'h0);
      chk("t3_next_result", 32'(result_out), 32'h00777);
      // 5: ack in the last WAIT cycle beats the watchdog
      issue(LD, 19'h00200, 19'h0, 3'd2, 16, 19'h2AAAA);
      chk("t5_result", 32'(result_out), 32'h2AAAA);
      chk("t5_rw", 32'(reg_write_out), 1);
      chk("t5_err", 32'(err_out), 0);
      // 4: never acked -> abort
      issue(LD, 19'h00300, 19'h0, 3'd1, 0, 19'h0);
      chk("t4_valid", 32'(valid_out), 1);
      chk("t4_rw", 32'(reg_write_out), 0);
      chk("t4_err", 32'(err_out), 1);
      chk("t4_req", 32'(mem.req), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_err_sticky", 32'(err_out), 1);
      // 6: reset during WAIT discards the access
      ack_at = 0;
      exp_addr = 10'h055;
      exp_we = 0;
      exp_wdata = '0;
      opcode_in = LD;
      alu_result_in = 19'h00055;
      store_data_in = '0;
      rd_in = 3'd1;
      valid_in = 1;
      @(posedge clk);
      #1;
      valid_in = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_req_before", 32'(mem.req), 1);
      chk("t6_stall_before", 32'(stall_out), 1);
      reset = 0;
      err_model = 0;
      @(posedge clk);
      #1;
      chk("t6_req", 32'(mem.req), 0);
      chk("t6_stall", 32'(stall_out), 0);
      chk("t6_valid", 32'(valid_out), 0);
      chk("t6_we", 32'(mem.we), 0);
      chk("t6_addr", 32'(mem.addr), 0);
      chk("t6_wdata", 32'(mem.wdata), 0);
      chk("t6_result", 32'(result_out), 0);
      chk("t6_rd", 32'(rd_out), 0);
      chk("t6_rw", 32'(reg_write_out), 0);
      chk("t6_err", 32'(err_out), 0);
      last_result = '0;
      reset = 1;
      @(posedge clk);
      #1;
      issue(ADD, 19'h00321, 19'h0, 3'd7, 0, 19'h0);
      chk("post_rst_result", 32'(result_out), 32'h00321);
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
